carry_select_adder: RTL and testbench

- Parameterized carry-select adder with a registered result: computes {cout, sum} = a + b + cin.
- The operand word is split into BLOCK_W-bit blocks. Block 0 is a plain ripple-carry adder (RCA).
- Every higher block holds two RCAs, one precomputed for carry-in 0 and one for carry-in 1. The actual carry from the block below selects the result through a mux.
- Used as a low-latency adder stage in datapaths; the result is captured in a pipeline register after one clock.

---
 rtl/csa_pkg.sv | 12 +
 rtl/rca_block.sv | 27 ++
 rtl/carry_select_adder.sv | 110 +++++++++++
 tb/tb_carry_select_adder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared constants and helpers for the carry-select adder and its ripple-carry blocks.
package csa_pkg;

    localparam int CSA_DEFAULT_WIDTH   = 32'sd4;
    localparam int CSA_DEFAULT_BLOCK_W = 32'sd2;

    // Number of carry-select blocks; callers guarantee width is a multiple of block_w.
    function automatic int num_blocks(input int width, input int block_w);
        return width / block_w;
    endfunction

endpackage

// File: rtl/rca_block.sv
// Purely combinational W-bit ripple-carry adder built from full-adder equations.
module rca_block #(
    parameter int W = 32'sd2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry_s;

    // Full-adder chain; carry_s[i] is the carry into bit i.
    always_comb begin
        carry_s    = '0;
        sum        = '0;
        carry_s[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry_s[W];

endmodule

// File: rtl/carry_select_adder.sv
// Carry-select adder with a one-cycle registered result: {cout, sum} = a + b + cin.
module carry_select_adder
    import csa_pkg::*;
#(
    parameter int WIDTH   = CSA_DEFAULT_WIDTH,
    parameter int BLOCK_W = CSA_DEFAULT_BLOCK_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    localparam int NB = num_blocks(WIDTH, BLOCK_W);

    if (WIDTH < 32'sd1 || BLOCK_W < 32'sd1 || (WIDTH % BLOCK_W) != 32'sd0) begin : g_bad_params
        $error("carry_select_adder: WIDTH must be >= 1 and a multiple of BLOCK_W");
    end

    logic [WIDTH-1:0] sum_comb_s;
    logic             cout_comb_s;

    // Each block exposes its own carry-in/out so the inter-block chain stays a pure mux path.
    for (genvar k = 0; k < NB; k++) begin : g_blk
        logic cin_s;
        logic cout_s;

        if (k == 0) begin : g_first
            assign cin_s = cin;
            rca_block #(.W(BLOCK_W)) u_rca (
                .a    (a[BLOCK_W-1:0]),
                .b    (b[BLOCK_W-1:0]),
                .cin  (cin_s),
                .sum  (sum_comb_s[BLOCK_W-1:0]),
                .cout (cout_s)
            );
        end else begin : g_select
            logic [BLOCK_W-1:0] s0_s;
            logic [BLOCK_W-1:0] s1_s;
            logic               c0_s;
            logic               c1_s;

            assign cin_s = g_blk[k-1].cout_s;

            rca_block #(.W(BLOCK_W)) u_rca_c0 (
                .a    (a[k*BLOCK_W +: BLOCK_W]),
                .b    (b[k*BLOCK_W +: BLOCK_W]),
                .cin  (1'b0),
                .sum  (s0_s),
                .cout (c0_s)
            );

            rca_block #(.W(BLOCK_W)) u_rca_c1 (
                .a    (a[k*BLOCK_W +: BLOCK_W]),
                .b    (b[k*BLOCK_W +: BLOCK_W]),
                .cin  (1'b1),
                .sum  (s1_s),
                .cout (c1_s)
            );

            assign sum_comb_s[k*BLOCK_W +: BLOCK_W] = cin_s ? s1_s : s0_s;
            assign cout_s                           = cin_s ? c1_s : c0_s;
        end
    end

    assign cout_comb_s = g_blk[NB-1].cout_s;

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             cout_d,  cout_q;
    logic             valid_d, valid_q;

    // Capture a new result only for valid operands; otherwise hold so idle inputs cannot disturb it.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = 1'b0;
        if (in_valid) begin
            sum_d   = sum_comb_s;
            cout_d  = cout_comb_s;
            valid_d = 1'b1;
        end else begin
            sum_d   = sum_q;
            cout_d  = cout_q;
            valid_d = 1'b0;
        end
    end

    // Output pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_carry_select_adder.sv
// Scoreboard bench for carry_select_adder at 4/2, 8/4 and 8/1 width/block configurations.
module tb_carry_select_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [3:0] a4, b4, sum4;
    logic       cin4, iv4, cout4, ov4;

    logic [7:0] a8, b8, sum8a, sum8b;
    logic       cin8, iv8, cout8a, cout8b, ov8a, ov8b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [5:0] q4[$];
    logic [9:0] q8[$];

    localparam logic [3:0] DA [5] = '{4'b1001, 4'b1101, 4'b0101, 4'b1100, 4'b1110};
    localparam logic [3:0] DB [5] = '{4'b1010, 4'b0110, 4'b0111, 4'b1011, 4'b0011};
    localparam logic       DC [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [3:0] DS [5] = '{4'b0011, 4'b0100, 4'b1101, 4'b0111, 4'b0010};
    localparam logic       DO [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    carry_select_adder #(.WIDTH(4), .BLOCK_W(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
        .sum(sum4), .cout(cout4), .out_valid(ov4)
    );

    carry_select_adder #(.WIDTH(8), .BLOCK_W(4)) u_dut8a (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
        .sum(sum8a), .cout(cout8a), .out_valid(ov8a)
    );

    carry_select_adder #(.WIDTH(8), .BLOCK_W(1)) u_dut8b (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
        .sum(sum8b), .cout(cout8b), .out_valid(ov8b)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        iv4 = 1'b1; iv8 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        end
        total_cnt++;
        if ({ov4, cout4, sum4} !== 6'd0) $display("FAIL reset_hold4 got=%b want=%b", {ov4, cout4, sum4}, 6'd0);
        else pass_cnt++;
        total_cnt++;
        if ({ov8a, cout8a, sum8a, ov8b, cout8b, sum8b} !== 20'd0)
            $display("FAIL reset_hold8 got=%h want=%h", {ov8a, cout8a, sum8a, ov8b, cout8b, sum8b}, 20'd0);
        else pass_cnt++;

        @(negedge clk);
        rst_n = 1'b1;
        iv8 = 1'b0;
        a4 = 4'd3; b4 = 4'd4; cin4 = 1'b0; iv4 = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({ov4, cout4, sum4} !== {1'b1, 1'b0, 4'd7}) $display("FAIL first_capture got=%b want=%b", {ov4, cout4, sum4}, {1'b1, 1'b0, 4'd7});
        else pass_cnt++;

        a4 = 4'd9; b4 = 4'd9; cin4 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({ov4, cout4, sum4} !== 6'd0) $display("FAIL reset_async got=%b want=%b", {ov4, cout4, sum4}, 6'd0);
        else pass_cnt++;

        @(negedge clk);
        rst_n = 1'b1;
        iv4 = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({ov4, cout4, sum4} !== 6'd0) $display("FAIL inflight_discard got=%b want=%b", {ov4, cout4, sum4}, 6'd0);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [5:0] exp;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (q4.size() > 0) begin
                exp = q4.pop_front();
                total_cnt++;
                if ({ov4, cout4, sum4} !== exp) $display("FAIL directed[%0d] got=%b want=%b", i - 1, {ov4, cout4, sum4}, exp);
                else pass_cnt++;
            end
            if (i < 5) begin
                a4 = DA[i]; b4 = DB[i]; cin4 = DC[i]; iv4 = 1'b1;
                q4.push_back({1'b1, DO[i], DS[i]});
            end else begin
                iv4 = 1'b0;
            end
        end
    endtask

    task automatic test_carry_prop();
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic       vc [3];
        logic [5:0] ve [3];
        logic [5:0] exp;
        va = '{4'b1111, 4'b1111, 4'b0000};
        vb = '{4'b0000, 4'b1111, 4'b0000};
        vc = '{1'b1, 1'b1, 1'b0};
        ve = '{6'b110000, 6'b111111, 6'b100000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (q4.size() > 0) begin
                exp = q4.pop_front();
                total_cnt++;
                if ({ov4, cout4, sum4} !== exp) $display("FAIL carry_prop[%0d] got=%b want=%b", i - 1, {ov4, cout4, sum4}, exp);
                else pass_cnt++;
            end
            if (i < 3) begin
                a4 = va[i]; b4 = vb[i]; cin4 = vc[i]; iv4 = 1'b1;
                q4.push_back(ve[i]);
            end else begin
                iv4 = 1'b0;
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        a4 = 4'b1001; b4 = 4'b1010; cin4 = 1'b0; iv4 = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({ov4, cout4, sum4} !== 6'b110011) $display("FAIL hold_load got=%b want=%b", {ov4, cout4, sum4}, 6'b110011);
        else pass_cnt++;
        iv4 = 1'b0; a4 = 4'b0110; b4 = 4'b0001; cin4 = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({ov4, cout4, sum4} !== 6'b010011) $display("FAIL hold_idle got=%b want=%b", {ov4, cout4, sum4}, 6'b010011);
        else pass_cnt++;
        a4 = 4'bxxxx; b4 = 4'bxxxx; cin4 = 1'bx;
        @(negedge clk);
        total_cnt++;
        if ({ov4, cout4, sum4} !== 6'b010011) $display("FAIL hold_xin got=%b want=%b", {ov4, cout4, sum4}, 6'b010011);
        else pass_cnt++;
        a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
    endtask

    task automatic test_exhaustive4();
        logic [5:0] exp;
        logic [4:0] ref_sum;
        int         errs = 0;
        for (int n = 0; n <= 512; n++) begin
            @(negedge clk);
            if (q4.size() > 0) begin
                exp = q4.pop_front();
                total_cnt++;
                if ({ov4, cout4, sum4} !== exp) begin
                    errs++;
                    if (errs <= 10) $display("FAIL exhaustive4[%0d] got=%b want=%b", n - 1, {ov4, cout4, sum4}, exp);
                end else pass_cnt++;
            end
            if (n < 512) begin
                a4 = 4'(n >> 5); b4 = 4'(n >> 1); cin4 = 1'(n);
                iv4 = 1'b1;
                ref_sum = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
                q4.push_back({1'b1, ref_sum});
            end else begin
                iv4 = 1'b0;
            end
        end
    endtask

    task automatic test_random_wide();
        logic [9:0] exp;
        logic [8:0] ref_sum;
        for (int n = 0; n <= 300; n++) begin
            @(negedge clk);
            if (q8.size() > 0) begin
                exp = q8.pop_front();
                total_cnt++;
                if ({ov8a, cout8a, sum8a} !== exp) $display("FAIL rand_w8b4[%0d] got=%b want=%b", n - 1, {ov8a, cout8a, sum8a}, exp);
                else pass_cnt++;
                total_cnt++;
                if ({ov8b, cout8b, sum8b} !== exp) $display("FAIL rand_w8b1[%0d] got=%b want=%b", n - 1, {ov8b, cout8b, sum8b}, exp);
                else pass_cnt++;
            end
            if (n < 300) begin
                if (n == 0)      begin a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; end
                else if (n == 1) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
                else begin a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); end
                iv8 = 1'b1;
                ref_sum = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
                q8.push_back({1'b1, ref_sum});
            end else begin
                iv8 = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; iv4 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0; iv8 = 1'b0;
        test_reset();
        test_directed();
        test_carry_prop();
        test_hold();
        test_exhaustive4();
        test_random_wide();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
